// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and encoder-to-id helper for the IRQ pending-capture block.
package irq_pkg;
  localparam int N_IRQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  // The encoder reports I[3] as y=00, so the line index is the bitwise inverse.
  function automatic logic [ID_W-1:0] enc2id(input logic [ID_W-1:0] y);
    return ~y;
  endfunction
endpackage

// File: rtl/irq_sync.sv
// Single-bit synchronizer, STAGES flops deep (2..3), cleared by synchronous reset.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/irq_pend_ctrl.sv
// Interrupt pending capture and valid/ack handshake in front of a 4x2 priority encoder.
// Optional sticky per-line overflow tracking is built when IRQ_OVF_EN is defined.
module irq_pend_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask,
  output logic [N_IRQ-1:0] pend_o,
  input  logic             enc_v,
  input  logic [ID_W-1:0]  enc_y,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack
`ifdef IRQ_OVF_EN
  ,
  output logic [N_IRQ-1:0] ovf,
  input  logic [N_IRQ-1:0] ovf_clr
`endif
);
  logic [N_IRQ-1:0] synced;
  logic [N_IRQ-1:0] prev_q, prev_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] edge_vec;
  logic [N_IRQ-1:0] clear_vec;
  state_e           state_q, state_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic             hold_q, hold_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_sync
      irq_sync #(
        .STAGES(SYNC_STAGES)
      ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (irq_in[gi]),
        .q  (synced[gi])
      );
    end
  endgenerate

  always_comb begin
    prev_d    = synced;
    edge_vec  = synced & ~prev_q;
    clear_vec = '0;
    if (state_q == ST_SERVE && irq_ack) begin
      clear_vec[irq_id_q] = 1'b1;
    end
    // OR-ing the edge after the clear lets a coincident new edge win.
    pend_d = (pend_q & ~clear_vec) | edge_vec;
  end

  // hold_q blocks capture for one edge after an ack so the encoder sees the cleared vector.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    hold_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_v && !hold_q) begin
          irq_id_d = enc2id(enc_y);
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (irq_ack) begin
          state_d = ST_IDLE;
          hold_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      pend_q   <= '0;
      state_q  <= ST_IDLE;
      irq_id_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
      hold_q   <= hold_d;
    end
  end

  assign pend_o    = pend_q & ~irq_mask;
  assign irq_valid = (state_q == ST_SERVE);
  assign irq_id    = irq_id_q;

`ifdef IRQ_OVF_EN
  logic [N_IRQ-1:0] ovf_q, ovf_d;

  // A bit being acked this cycle is not "already pending" for a coincident edge.
  always_comb begin
    ovf_d = (ovf_q & ~ovf_clr) | (edge_vec & pend_q & ~clear_vec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Scoreboard bench for irq_pend_ctrl with a behavioural encoder in the loop (SYNC_STAGES=2).
module tb_irq_pend_ctrl;
  import irq_pkg::*;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic [3:0] pend_o;
  logic       enc_v;
  logic [1:0] enc_y;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;
`ifdef IRQ_OVF_EN
  logic [3:0] ovf;
  logic [3:0] ovf_clr;
`endif

  always #5 clk = ~clk;

  irq_pend_ctrl #(
    .SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .irq_mask (irq_mask),
    .pend_o   (pend_o),
    .enc_v    (enc_v),
    .enc_y    (enc_y),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack)
`ifdef IRQ_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`endif
  );

  // 4x2 priority encoder: I[3] highest, y=00 for I[3] ... y=11 for I[0].
  always_comb begin
    enc_v = |pend_o;
    enc_y = 2'd3;
    if (pend_o[3])      enc_y = 2'd0;
    else if (pend_o[2]) enc_y = 2'd1;
    else if (pend_o[1]) enc_y = 2'd2;
  end

  typedef struct {
    logic [3:0] pend;
    logic       valid;
    logic [1:0] id;
    logic       chk_id;
    logic [3:0] ovf;
  } exp_t;

  exp_t expq[$];
  int   idq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: requests seen, which line is being served, etc.
  bit [3:0] m_pend;
  bit [3:0] m_ovf;
  bit       m_serve;
  bit       m_hold;
  bit       m_was_rst;
  int       m_id;
  bit [3:0] m_smp[$];  // irq_in as sampled at each past edge, newest first

  function automatic int top_bit(input bit [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit [3:0] in, input bit [3:0] mk,
                            input bit ack, input bit [3:0] clr);
    bit [3:0] synced, prev, edg, clrv, vis;
    if (r) begin
      m_pend = '0; m_ovf = '0; m_serve = 0; m_hold = 0; m_id = 0; m_was_rst = 1;
      m_smp.delete();
      for (int i = 0; i <= S; i++) m_smp.push_back(4'b0);
    end else begin
      m_was_rst = 0;
      synced = m_smp[S-1];
      prev   = m_smp[S];
      edg    = synced & ~prev;
      clrv   = '0;
      if (m_serve && ack) clrv[m_id] = 1'b1;
      vis    = m_pend & ~mk;
      m_ovf  = (m_ovf & ~clr) | (edg & m_pend & ~clrv);
      m_pend = (m_pend & ~clrv) | edg;
      if (!m_serve) begin
        if (vis != 0 && !m_hold) begin
          m_id    = top_bit(vis);
          m_serve = 1;
          idq.push_back(m_id);
        end
        m_hold = 0;
      end else begin
        m_hold = ack;
        if (ack) m_serve = 0;
      end
      m_smp.push_front(in);
      void'(m_smp.pop_back());
    end
  endtask

  // ack modes: 0 none, 1 forced, 2 whenever serving, 3 randomly while serving
  task automatic cyc(input bit r, input bit [3:0] in, input bit [3:0] mk,
                     input int am, input bit [3:0] clr);
    bit   a;
    exp_t e;
    @(posedge clk);
    #2;
    a = (am == 1) || (am == 2 && m_serve) || (am == 3 && m_serve && $urandom_range(0, 2) == 0);
    rst      = r;
    irq_in   = in;
    irq_mask = mk;
    irq_ack  = a;
`ifdef IRQ_OVF_EN
    ovf_clr  = clr;
`endif
    e.pend   = m_pend & ~mk;
    e.valid  = m_serve;
    e.id     = 2'(m_id);
    e.chk_id = m_serve || m_was_rst;
    e.ovf    = m_ovf;
    expq.push_back(e);
    model_step(r, in, mk, a, clr);
  endtask

  task automatic do_reset();
    repeat (2) cyc(1, 4'b0, 4'b0, 0, 4'b0);
    repeat (2) cyc(0, 4'b0, 4'b0, 0, 4'b0);
  endtask

  // Monitor: compares every cycle and pops the request queue on each new presentation.
  logic prev_v = 1'b0;
  initial begin
    exp_t e;
    int   want;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("pend_o", {4'b0, pend_o}, {4'b0, e.pend});
        check("irq_valid", {7'b0, irq_valid}, {7'b0, e.valid});
        if (e.chk_id) check("irq_id", {6'b0, irq_id}, {6'b0, e.id});
`ifdef IRQ_OVF_EN
        check("ovf", {4'b0, ovf}, {4'b0, e.ovf});
`endif
      end
      if (irq_valid === 1'b1 && !prev_v) begin
        if (idq.size() == 0) begin
          check("unexpected_req", {6'b0, irq_id}, 8'hff);
        end else begin
          want = idq.pop_front();
          check("req_id", {6'b0, irq_id}, 8'(want));
          $display("request presented: irq_id=%0d expected=%0d t=%0t", irq_id, want, $time);
        end
      end
      prev_v = irq_valid;
    end
  end

  initial begin
    bit [3:0] in_r;
    bit [3:0] mk_r;
    bit [3:0] clr_r;
    bit       r_r;
    rst = 1'b1; irq_in = '0; irq_mask = '0; irq_ack = 1'b0;
`ifdef IRQ_OVF_EN
    ovf_clr = '0;
`endif
    model_step(1, 4'b0, 4'b0, 0, 4'b0);

    // Single line: latency to pending/valid, then ack clears it.
    do_reset();
    repeat (5) cyc(0, 4'b0001, 4'b0, 0, 4'b0);
    cyc(0, 4'b0001, 4'b0, 1, 4'b0);
    repeat (3) cyc(0, 4'b0001, 4'b0, 0, 4'b0);

    // Two simultaneous lines: priority order and post-ack gap.
    do_reset();
    repeat (12) cyc(0, 4'b1010, 4'b0, 2, 4'b0);

    // Masked higher line is retained and served once unmasked.
    do_reset();
    repeat (10) cyc(0, 4'b1100, 4'b1000, 2, 4'b0);
    repeat (8) cyc(0, 4'b1100, 4'b0000, 2, 4'b0);

    // New edge on line 2 coincides with its ack, then a lost edge and overflow clear.
    do_reset();
    cyc(0, 4'b0100, 4'b0, 0, 4'b0);
    repeat (3) cyc(0, 4'b0000, 4'b0, 0, 4'b0);
    repeat (2) cyc(0, 4'b0100, 4'b0, 0, 4'b0);
    cyc(0, 4'b0100, 4'b0, 1, 4'b0);
    repeat (3) cyc(0, 4'b0100, 4'b0, 0, 4'b0);
    repeat (2) cyc(0, 4'b0000, 4'b0, 0, 4'b0);
    repeat (3) cyc(0, 4'b0100, 4'b0, 0, 4'b0);
    cyc(0, 4'b0100, 4'b0, 0, 4'b0100);
    repeat (4) cyc(0, 4'b0100, 4'b0, 2, 4'b0);

    // Reset while serving with lines held high.
    do_reset();
    repeat (5) cyc(0, 4'b0110, 4'b0, 0, 4'b0);
    cyc(1, 4'b0110, 4'b0, 0, 4'b0);
    repeat (8) cyc(0, 4'b0110, 4'b0, 2, 4'b0);

    // Random traffic.
    in_r = '0;
    mk_r = '0;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) in_r[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) mk_r = 4'($urandom);
      r_r   = ($urandom_range(0, 149) == 0);
      clr_r = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      cyc(r_r, in_r, mk_r, 3, clr_r);
    end
    repeat (6) cyc(0, 4'b0, 4'b0, 2, 4'b0);

    @(negedge clk);
    #1;
    check("req_queue_drained", 8'(idq.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
